tank_shell: RTL and testbench

TANK_SHELL -- requirements
Module: tank_shell

---
 rtl/tank_shell.sv | 194 +++++++++++++++++++
 tb/tb_tank_shell.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/tank_shell.sv
// Purpose : single tank shell - fire-edge capture, frame-rate flight, screen-edge/hit retire, cooldown.
// Latency : launch/move registered one Clk after the internal frame_tick pulse; hit retires at next Clk.
// Backpress: none; fire edges outside IDLE are dropped, never queued.
// Ports   : Clk/Reset (async active-low); frame_clk, fire, tank_X/Y/dir, hit, DrawX/Y in;
//           shell_X/Y/dir, shell_active, is_shell (combinational), shots_fired out.
module tank_shell #(
  parameter logic [9:0] Shell_Step      = 10'd4,
  parameter logic [9:0] Shell_Size      = 10'd4,
  parameter logic [5:0] Cooldown_Frames = 6'd30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       fire,
  input  logic [9:0] tank_X,
  input  logic [9:0] tank_Y,
  input  logic [2:0] tank_dir,
  input  logic       hit,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] shell_X,
  output logic [9:0] shell_Y,
  output logic [2:0] shell_dir,
  output logic       shell_active,
  output logic       is_shell,
  output logic [7:0] shots_fired
);

  typedef enum logic [1:0] {IDLE, FLY, COOLDOWN} state_t;

  localparam logic [2:0] DIR_UP    = 3'd1;
  localparam logic [2:0] DIR_RIGHT = 3'd2;
  localparam logic [2:0] DIR_LEFT  = 3'd3;
  localparam logic [2:0] DIR_DOWN  = 3'd4;

  localparam logic signed [10:0] X_MAX = 11'sd636;
  localparam logic signed [10:0] Y_MAX = 11'sd476;

  state_t      state_q, state_d;
  logic        frame_dly_q, frame_dly_d;
  logic        frame_tick_q, frame_tick_d;
  logic        fire_dly_q, fire_dly_d;
  logic        pending_q, pending_d;
  logic [5:0]  cd_cnt_q, cd_cnt_d;
  logic [9:0]  shell_x_q, shell_x_d;
  logic [9:0]  shell_y_q, shell_y_d;
  logic [2:0]  shell_dir_q, shell_dir_d;
  logic        shell_active_q, shell_active_d;
  logic [7:0]  shots_q, shots_d;

  // 11-bit signed intermediates so positions left/above the screen show up negative.
  logic signed [10:0] tx_s, ty_s, sx_s, sy_s, step_s;
  logic signed [10:0] spawn_x, spawn_y, next_x, next_y;
  logic               dir_valid, fire_rise;

  function automatic logic in_range(input logic signed [10:0] x, input logic signed [10:0] y);
    in_range = !x[10] && (x <= X_MAX) && !y[10] && (y <= Y_MAX);
  endfunction

  always_comb begin
    tx_s      = signed'({1'b0, tank_X});
    ty_s      = signed'({1'b0, tank_Y});
    sx_s      = signed'({1'b0, shell_x_q});
    sy_s      = signed'({1'b0, shell_y_q});
    step_s    = signed'({1'b0, Shell_Step});
    dir_valid = (tank_dir >= DIR_UP) && (tank_dir <= DIR_DOWN);
    fire_rise = fire & ~fire_dly_q;

    // Spawn just ahead of the 32x32 tank's barrel, centred on its facing edge.
    spawn_x = tx_s;
    spawn_y = ty_s;
    case (tank_dir)
      DIR_UP:    begin spawn_x = tx_s + 11'sd14; spawn_y = ty_s - 11'sd4;  end
      DIR_RIGHT: begin spawn_x = tx_s + 11'sd32; spawn_y = ty_s + 11'sd14; end
      DIR_LEFT:  begin spawn_x = tx_s - 11'sd4;  spawn_y = ty_s + 11'sd14; end
      DIR_DOWN:  begin spawn_x = tx_s + 11'sd14; spawn_y = ty_s + 11'sd32; end
      default:   begin spawn_x = tx_s;           spawn_y = ty_s;           end
    endcase

    next_x = sx_s;
    next_y = sy_s;
    case (shell_dir_q)
      DIR_UP:    next_y = sy_s - step_s;
      DIR_RIGHT: next_x = sx_s + step_s;
      DIR_LEFT:  next_x = sx_s - step_s;
      DIR_DOWN:  next_y = sy_s + step_s;
      default:   next_x = sx_s;
    endcase
  end

  always_comb begin
    frame_dly_d  = frame_clk;
    frame_tick_d = frame_clk & ~frame_dly_q;
    fire_dly_d   = fire;
    state_d      = state_q;
    pending_d    = pending_q;
    cd_cnt_d     = cd_cnt_q;
    shell_x_d    = shell_x_q;
    shell_y_d    = shell_y_q;
    shell_dir_d  = shell_dir_q;
    shots_d      = shots_q;

    case (state_q)
      IDLE: begin
        if (frame_tick_q && pending_q) begin
          // A pending request is consumed by this tick whether or not it launches.
          pending_d = 1'b0;
          if (dir_valid) begin
            shots_d     = shots_q + 8'd1;
            shell_dir_d = tank_dir;
            if (in_range(spawn_x, spawn_y)) begin
              shell_x_d = spawn_x[9:0];
              shell_y_d = spawn_y[9:0];
              state_d   = FLY;
            end else begin
              cd_cnt_d = 6'd0;
              state_d  = COOLDOWN;
            end
          end
        end else if (fire_rise) begin
          pending_d = 1'b1;
        end
      end
      FLY: begin
        // hit outranks a coincident frame tick: retire without moving.
        if (hit) begin
          cd_cnt_d = 6'd0;
          state_d  = COOLDOWN;
        end else if (frame_tick_q) begin
          if (in_range(next_x, next_y)) begin
            shell_x_d = next_x[9:0];
            shell_y_d = next_y[9:0];
          end else begin
            cd_cnt_d = 6'd0;
            state_d  = COOLDOWN;
          end
        end
      end
      COOLDOWN: begin
        if (frame_tick_q) begin
          if (cd_cnt_q == Cooldown_Frames - 6'd1) begin
            state_d = IDLE;
          end else begin
            cd_cnt_d = cd_cnt_q + 6'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    shell_active_d = (state_d == FLY);
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q        <= IDLE;
      frame_dly_q    <= 1'b0;
      frame_tick_q   <= 1'b0;
      fire_dly_q     <= 1'b0;
      pending_q      <= 1'b0;
      cd_cnt_q       <= 6'd0;
      shell_x_q      <= 10'd0;
      shell_y_q      <= 10'd0;
      shell_dir_q    <= 3'd0;
      shell_active_q <= 1'b0;
      shots_q        <= 8'd0;
    end else begin
      state_q        <= state_d;
      frame_dly_q    <= frame_dly_d;
      frame_tick_q   <= frame_tick_d;
      fire_dly_q     <= fire_dly_d;
      pending_q      <= pending_d;
      cd_cnt_q       <= cd_cnt_d;
      shell_x_q      <= shell_x_d;
      shell_y_q      <= shell_y_d;
      shell_dir_q    <= shell_dir_d;
      shell_active_q <= shell_active_d;
      shots_q        <= shots_d;
    end
  end

  assign shell_X      = shell_x_q;
  assign shell_Y      = shell_y_q;
  assign shell_dir    = shell_dir_q;
  assign shell_active = shell_active_q;
  assign shots_fired  = shots_q;

  assign is_shell = shell_active_q
                 && ({1'b0, DrawX} >= {1'b0, shell_x_q})
                 && ({1'b0, DrawX} <= {1'b0, shell_x_q} + {1'b0, Shell_Size} - 11'd1)
                 && ({1'b0, DrawY} >= {1'b0, shell_y_q})
                 && ({1'b0, DrawY} <= {1'b0, shell_y_q} + {1'b0, Shell_Size} - 11'd1);

endmodule

// File: tb/tb_tank_shell.sv
// Purpose : self-checking bench for tank_shell; expected shell state is queued with each stimulus step.
// Latency : each frame tick is observed two Clk edges after frame_clk rises.
// Backpress: none.
module tb_tank_shell;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       frame_clk;
  logic       fire;
  logic [9:0] tank_X, tank_Y;
  logic [2:0] tank_dir;
  logic       hit;
  logic [9:0] DrawX, DrawY;
  logic [9:0] shell_X, shell_Y;
  logic [2:0] shell_dir;
  logic       shell_active, is_shell;
  logic [7:0] shots_fired;

  always #10 Clk = ~Clk;

  tank_shell dut (
    .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .fire(fire),
    .tank_X(tank_X), .tank_Y(tank_Y), .tank_dir(tank_dir), .hit(hit),
    .DrawX(DrawX), .DrawY(DrawY),
    .shell_X(shell_X), .shell_Y(shell_Y), .shell_dir(shell_dir),
    .shell_active(shell_active), .is_shell(is_shell), .shots_fired(shots_fired)
  );

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       act;
    logic [7:0] shots;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  int    n_chk  = 0;
  int    n_fail = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic push_exp(input string tag, input int x, input int y, input int act, input int shots);
    exp_t e;
    e.x     = 10'(x);
    e.y     = 10'(y);
    e.act   = 1'(act);
    e.shots = 8'(shots);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic pop_check();
    exp_t  e;
    string t;
    check_val("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      check_val({t, ".x"},      32'(shell_X),      32'(e.x));
      check_val({t, ".y"},      32'(shell_Y),      32'(e.y));
      check_val({t, ".active"}, 32'(shell_active), 32'(e.act));
      check_val({t, ".shots"},  32'(shots_fired),  32'(e.shots));
    end
  endtask

  // frame_clk rises, tick pulse registers on the next edge, FSM acts on the one after.
  task automatic tick();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) frame_clk = 1'b0;
    @(negedge Clk);
  endtask

  task automatic fire_pulse();
    @(negedge Clk) fire = 1'b1;
    @(negedge Clk) fire = 1'b0;
  endtask

  task automatic hit_pulse();
    @(negedge Clk) hit = 1'b1;
    @(negedge Clk) hit = 1'b0;
  endtask

  task automatic hit_with_tick();
    @(negedge Clk) frame_clk = 1'b1;
    @(negedge Clk) begin frame_clk = 1'b0; hit = 1'b1; end
    @(negedge Clk) hit = 1'b0;
  endtask

  task automatic probe(input string tag, input int dx, input int dy, input int exp);
    DrawX = 10'(dx);
    DrawY = 10'(dy);
    #1;
    check_val(tag, 32'(is_shell), 32'(exp));
  endtask

  task automatic set_tank(input int x, input int y, input int d);
    tank_X   = 10'(x);
    tank_Y   = 10'(y);
    tank_dir = 3'(d);
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: run still active at time limit, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    Reset = 1'b0; frame_clk = 1'b0; fire = 1'b0; hit = 1'b0;
    set_tank(0, 0, 0);
    DrawX = 10'd0; DrawY = 10'd0;
    repeat (3) @(negedge Clk);
    push_exp("reset", 0, 0, 0, 0);
    pop_check();
    check_val("reset.dir", 32'(shell_dir), 32'd0);
    probe("reset.is_shell", 0, 0, 0);
    @(negedge Clk) Reset = 1'b1;

    // UP launch, then a move; tank motion after launch must not matter.
    set_tank(100, 380, 1);
    fire_pulse();
    push_exp("up.launch", 114, 376, 1, 1);
    tick();
    pop_check();
    check_val("up.dir", 32'(shell_dir), 32'd1);
    probe("up.px_tl", 114, 376, 1);
    probe("up.px_br", 117, 379, 1);
    probe("up.px_right", 118, 377, 0);
    probe("up.px_left", 113, 377, 0);
    probe("up.px_below", 115, 380, 0);
    set_tank(300, 100, 2);
    push_exp("up.step", 114, 372, 1, 1);
    tick();
    pop_check();

    // hit between ticks retires; fire edge during cooldown is dropped.
    push_exp("up.hit", 114, 372, 0, 1);
    hit_pulse();
    pop_check();
    repeat (29) tick();
    fire_pulse();
    push_exp("cd.tick30", 114, 372, 0, 1);
    tick();
    pop_check();
    push_exp("cd.discard", 114, 372, 0, 1);
    tick();
    pop_check();

    // Off-screen spawn goes straight to cooldown.
    set_tank(100, 0, 1);
    fire_pulse();
    push_exp("offspawn", 114, 372, 0, 2);
    tick();
    pop_check();
    repeat (30) tick();

    // RIGHT at the X edge, fire held high throughout.
    set_tank(604, 200, 2);
    @(negedge Clk) fire = 1'b1;
    @(negedge Clk);
    push_exp("right.launch", 636, 214, 1, 3);
    tick();
    pop_check();
    check_val("right.dir", 32'(shell_dir), 32'd2);
    probe("right.px_edge", 639, 217, 1);
    probe("right.px_out", 640, 217, 0);
    @(negedge Clk) fire = 1'b0;
    @(negedge Clk) fire = 1'b1;
    @(negedge Clk);
    push_exp("right.edge", 636, 214, 0, 3);
    tick();
    pop_check();
    repeat (30) tick();
    push_exp("right.held", 636, 214, 0, 3);
    tick();
    pop_check();
    @(negedge Clk) fire = 1'b0;

    // DOWN launch, then hit coinciding with a frame tick.
    set_tank(200, 200, 4);
    fire_pulse();
    push_exp("down.launch", 214, 232, 1, 4);
    tick();
    pop_check();
    push_exp("down.hit_tick", 214, 232, 0, 4);
    hit_with_tick();
    pop_check();
    repeat (30) tick();

    // Invalid directions consume the request without launching.
    set_tank(200, 200, 0);
    fire_pulse();
    push_exp("bad_dir0", 214, 232, 0, 4);
    tick();
    pop_check();
    tank_dir = 3'd1;
    push_exp("bad_dir.no_retry", 214, 232, 0, 4);
    tick();
    pop_check();
    tank_dir = 3'd7;
    fire_pulse();
    push_exp("bad_dir7", 214, 232, 0, 4);
    tick();
    pop_check();

    // LEFT launch and step.
    set_tank(50, 100, 3);
    fire_pulse();
    push_exp("left.launch", 46, 114, 1, 5);
    tick();
    pop_check();
    push_exp("left.step", 42, 114, 1, 5);
    tick();
    pop_check();
    probe("left.px_pre_rst", 42, 114, 1);

    // Asynchronous reset mid-flight.
    @(negedge Clk);
    #3 Reset = 1'b0;
    #1;
    push_exp("rst.async", 0, 0, 0, 0);
    pop_check();
    check_val("rst.dir", 32'(shell_dir), 32'd0);
    probe("rst.is_shell", 0, 0, 0);
    @(negedge Clk) Reset = 1'b1;
    push_exp("rst.no_fire", 0, 0, 0, 0);
    tick();
    pop_check();

    // Counter wrap using off-screen spawns.
    set_tank(100, 0, 1);
    for (int i = 0; i < 255; i++) begin
      fire_pulse();
      tick();
      repeat (30) tick();
    end
    push_exp("wrap.255", 0, 0, 0, 255);
    pop_check();
    fire_pulse();
    push_exp("wrap.0", 0, 0, 0, 0);
    tick();
    pop_check();

    check_val("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
